// File: rtl/dff_share_arbiter.sv
// rtl/dff_share_arbiter.sv - round-robin write arbiter owning one shared WIDTH-bit register
module dff_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [IDX_W-1:0]         owner,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   sel, sel_nxt;
    logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               q_valid_nxt;
    logic [IDX_W-1:0]   owner_nxt;
    logic               busy_nxt;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;

    // Rotating search: first requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (req[idx] && !found) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        grant_nxt   = '0;
        ack_nxt     = '0;
        q_nxt       = q;
        q_valid_nxt = q_valid;
        owner_nxt   = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt   = pick;
                    grant_nxt = NUM_REQ'(1) << pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A withdrawn request aborts without writing and keeps ptr.
                if (req[sel]) begin
                    q_nxt       = wr_data[int'(sel)*WIDTH +: WIDTH];
                    owner_nxt   = sel;
                    q_valid_nxt = 1'b1;
                    ack_nxt     = NUM_REQ'(1) << sel;
                    state_nxt   = ACK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                ptr_nxt   = sel + IDX_W'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            grant   <= '0;
            ack     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            sel     <= sel_nxt;
            grant   <= grant_nxt;
            ack     <= ack_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule
